// File: rtl/refr_temp_derate_pkg.sv
// refr_temp_derate_pkg: shared thermal states, scale codes and default thresholds for refresh derating
package refr_temp_derate_pkg;

    typedef enum logic [1:0] {
        T_INIT = 2'd0,
        T_NORM = 2'd1,
        T_HOT  = 2'd2,
        T_CRIT = 2'd3
    } temp_state_t;

    localparam logic [1:0] SCALE_1X = 2'd0;
    localparam logic [1:0] SCALE_2X = 2'd1;
    localparam logic [1:0] SCALE_4X = 2'd2;

    localparam logic [7:0]  DEF_HOT_TH    = 8'd85;
    localparam logic [7:0]  DEF_CRIT_TH   = 8'd95;
    localparam logic [7:0]  DEF_HYST      = 8'd5;
    localparam int          DEF_COOL_CNT  = 4;
    localparam logic [31:0] DEF_STALE_PER = 32'd2_000_000;

    // INIT is treated as worst case until the first sample arrives
    function automatic logic [1:0] target_scale(input temp_state_t s);
        return (s == T_NORM) ? SCALE_1X : (s == T_HOT) ? SCALE_2X : SCALE_4X;
    endfunction

endpackage

// File: rtl/refr_temp_watchdog.sv
// refr_temp_watchdog: counts cycles since the last temperature sample and pulses once when STALE_PER is reached
module refr_temp_watchdog
    import refr_temp_derate_pkg::*;
#(
    parameter logic [31:0] STALE_PER = DEF_STALE_PER
) (
    input  logic clk,
    input  logic rst_n,
    input  logic temp_valid,
    output logic expire
);

    logic [31:0] cnt_q, cnt_d;

    // count idle cycles, saturate at the limit, restart on every sample; a sample in the expiry cycle suppresses the pulse
    always_comb begin
        cnt_d  = temp_valid ? 32'd0 : (cnt_q == STALE_PER) ? cnt_q : cnt_q + 32'd1;
        expire = !temp_valid && (cnt_q + 32'd1 == STALE_PER);
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/refr_temp_derate.sv
// refr_temp_derate: classifies temperature samples with hysteresis and derates tREFIab/tREFIpb while the refresh handler is idle
// Optional stale-sample watchdog enabled by defining TEMP_WATCHDOG_EN.
module refr_temp_derate
    import refr_temp_derate_pkg::*;
#(
    parameter logic [7:0]  HOT_TH    = DEF_HOT_TH,
    parameter logic [7:0]  CRIT_TH   = DEF_CRIT_TH,
    parameter logic [7:0]  HYST      = DEF_HYST,
    parameter int          COOL_CNT  = DEF_COOL_CNT,
    parameter logic [31:0] STALE_PER = DEF_STALE_PER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        temp_valid,
    input  logic [7:0]  temp_data,
    input  logic        ref_idle,
    input  logic [31:0] base_refi_ab,
    input  logic [31:0] base_refi_pb,
    output logic [31:0] refi_ab_eff,
    output logic [31:0] refi_pb_eff,
    output logic [1:0]  refi_scale,
    output logic        temp_alarm,
    output logic        temp_stale,
    output logic [7:0]  temp_max
);

    localparam logic [7:0] HOT_COOL  = HOT_TH - HYST;
    localparam logic [7:0] CRIT_COOL = CRIT_TH - HYST;
    localparam logic [3:0] COOL_N    = 4'(COOL_CNT);

    temp_state_t state_q, state_d;
    logic [3:0]  cool_q, cool_d, cool_inc;
    logic [1:0]  scale_q, scale_d;
    logic [31:0] ab_q, ab_d, pb_q, pb_d, ab_sh, pb_sh;
    logic        alarm_q, alarm_d;
    logic [7:0]  max_q, max_d;
    logic        expire;

`ifdef TEMP_WATCHDOG_EN
    logic stale_q, stale_d;

    refr_temp_watchdog #(.STALE_PER(STALE_PER)) u_wdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp_valid (temp_valid),
        .expire     (expire)
    );

    // stale flag rises on expiry and is cleared by the next sample
    always_comb begin
        stale_d = temp_valid ? 1'b0 : expire ? 1'b1 : stale_q;
    end

    // stale flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stale_q <= 1'b0;
        else        stale_q <= stale_d;
    end

    assign temp_stale = stale_q;
`else
    logic unused_stale_per;
    assign unused_stale_per = ^STALE_PER;
    assign expire           = 1'b0;
    assign temp_stale       = 1'b0;
`endif

    // thermal FSM: heat up immediately, cool down one state after COOL_CNT consecutive cool samples
    always_comb begin
        state_d  = state_q;
        cool_d   = cool_q;
        cool_inc = cool_q + 4'd1;
        if (temp_valid) begin
            unique case (state_q)
                T_INIT, T_NORM: begin
                    state_d = (temp_data >= CRIT_TH) ? T_CRIT : (temp_data >= HOT_TH) ? T_HOT : T_NORM;
                    cool_d  = '0;
                end
                T_HOT: begin
                    if (temp_data >= CRIT_TH) begin
                        state_d = T_CRIT;
                        cool_d  = '0;
                    end else if (temp_data < HOT_COOL) begin
                        state_d = (cool_inc == COOL_N) ? T_NORM : T_HOT;
                        cool_d  = (cool_inc == COOL_N) ? 4'd0 : cool_inc;
                    end else begin
                        cool_d  = '0;
                    end
                end
                T_CRIT: begin
                    if (temp_data < CRIT_COOL) begin
                        state_d = (cool_inc == COOL_N) ? T_HOT : T_CRIT;
                        cool_d  = (cool_inc == COOL_N) ? 4'd0 : cool_inc;
                    end else begin
                        cool_d  = '0;
                    end
                end
            endcase
        end else if (expire) begin
            state_d = T_INIT;
            cool_d  = '0;
        end
    end

    // apply stage, derate arithmetic with a floor of 1, alarm and sticky maximum
    always_comb begin
        scale_d = ref_idle ? target_scale(state_q) : scale_q;
        ab_sh   = base_refi_ab >> scale_q;
        pb_sh   = base_refi_pb >> scale_q;
        ab_d    = (ab_sh == '0) ? 32'd1 : ab_sh;
        pb_d    = (pb_sh == '0) ? 32'd1 : pb_sh;
        alarm_d = (state_q == T_CRIT);
        max_d   = (temp_valid && temp_data > max_q) ? temp_data : max_q;
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_INIT;
            cool_q  <= '0;
            scale_q <= SCALE_4X;
            ab_q    <= '0;
            pb_q    <= '0;
            alarm_q <= 1'b0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            cool_q  <= cool_d;
            scale_q <= scale_d;
            ab_q    <= ab_d;
            pb_q    <= pb_d;
            alarm_q <= alarm_d;
            max_q   <= max_d;
        end
    end

    assign refi_ab_eff = ab_q;
    assign refi_pb_eff = pb_q;
    assign refi_scale  = scale_q;
    assign temp_alarm  = alarm_q;
    assign temp_max    = max_q;

endmodule
